mul_controller: RTL
===================

# mul_controller

Sequencing FSM for `mul_datapath`, the 16-bit multiply-by-repeated-addition unit. It accepts a `start` request and fetches operand A, then operand B, from the shared `data_in` bus using a valid/ready handshake. It then drives the datapath strobes (`ldA`, `ldB`, `clrP`, `ldP`, `decB`) until the datapath reports `eqz`, and signals completion. It also reports busy status, an iteration count and an abort indication to the surrounding system.

## Interface
- `CNT_W`, 16, width of `iter_count` (matches the datapath operand width)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a multiply; sampled only in IDLE
- `in_valid`  in  1  `data_in` currently holds the next operand
- `abort`  in  1  cancel the operation in progress
- `eqz`  in  1  from datapath: B register == 0 (combinational)
- `in_ready`  out  1  controller waiting for an operand
- `ldA`  out  1  datapath: load A from `data_in`
- `ldB`  out  1  datapath: load B from `data_in`
- `clrP`  out  1  datapath: clear P
- `ldP`  out  1  datapath: P <= P + A
- `decB`  out  1  datapath: B <= B - 1
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the product is valid in P
- `aborted`  out  1  one-cycle registered pulse after an abort is taken
- `iter_count`  out  CNT_W  number of accumulate iterations performed

## Operation
- States: IDLE, LOAD_A, LOAD_B, ACCUM, DONE. The state register is held in a dedicated register.
- Strobes are combinational decodes of state and inputs.
- `busy`, `done` and `in_ready` decode from state only.
- IDLE: all strobes 0. `start`=1 moves to LOAD_A and clears `iter_count` to 0.
- LOAD_A: `in_ready`=1. When `in_valid`=1, assert `ldA` in that cycle and move to LOAD_B. Otherwise hold with no strobe.
- LOAD_B: `in_ready`=1. When `in_valid`=1, assert `ldB` and `clrP` in the same cycle and move to ACCUM. Otherwise hold.
- ACCUM, `eqz`=0: assert `ldP` and `decB` together, increment `iter_count` (saturating at all-ones), stay in ACCUM.
- ACCUM, `eqz`=1: no strobes, move to DONE.
- DONE: `done`=1, no strobes, unconditional return to IDLE. `start` is ignored in DONE.
- `abort` in LOAD_A, LOAD_B or ACCUM:
  - takes priority over `in_valid` and `eqz`;
  - no strobes are asserted that cycle;
  - next state is IDLE and `aborted` pulses in the following cycle;
  - `done` is not asserted and `iter_count` holds its value.
- `abort` in IDLE or DONE is ignored.
- `start` while `busy` is ignored and is not queued.
- `iter_count` holds its value after DONE or abort until the next accepted `start`.
- The product is correct modulo 2^16; overflow is the datapath's concern and is not flagged here.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state = IDLE, `iter_count` = 0, `aborted` = 0;
  - all strobes, `busy`, `done` and `in_ready` go to 0 immediately, without waiting for a clock edge;
  - datapath registers are not reset by this block.
- Reset asserted mid-operation abandons the operation silently: no `done`, no `aborted`.
- Latency, with `start` sampled at edge E0 and `in_valid` held high:
  - LOAD_A in cycle 1, LOAD_B in cycle 2;
  - ACCUM from cycle 3 to cycle B+3;
  - `done` high in cycle B+4.
- Each cycle of `in_valid` low in a LOAD state adds one cycle of latency.
- `ldP`/`decB` are asserted for exactly B cycles, and they are always consecutive.
- B = 0 gives zero accumulate cycles and `done` in cycle 4.
- The cycle after DONE is IDLE; a new `start` there is accepted (one idle cycle between operations).

## Test plan
- Reset: assert `rst_n`=0 in the 2nd ACCUM cycle -> `ldP`/`decB`/`busy` drop to 0 before the next edge; after release, state is IDLE, `iter_count`=0 and no `done` pulse occurs.
- Normal: `start`, A=16'h14, B=16'h3, `in_valid` held high -> `ldA` in cycle 1, `ldB`+`clrP` in cycle 2, `ldP`+`decB` in cycles 3-5, `done` in cycle 7, `iter_count`=3, datapath P=16'h3C.
- Zero operand: A=16'h20, B=0 -> no `ldP`/`decB`, `done` in cycle 4, `iter_count`=0, P=0.
- Handshake stall: `in_valid` low for 3 cycles in LOAD_A, then A=16'h20, B=16'h2 -> `in_ready` stays high and no `ldA` during the stall; `done` arrives 3 cycles later than unstalled (cycle 9); P=16'h40.
- Abort: B=5, `abort`=1 in the 3rd ACCUM cycle -> no strobes that cycle; IDLE next cycle with `aborted` pulsing once; no `done`; `iter_count`=2.
- Ignored start: pulse `start` during ACCUM -> no effect on sequence or `iter_count`. `start` asserted in the cycle after DONE -> accepted, and LOAD_A follows.

Source files
------------

// File: rtl/mul_controller_if.sv
// Handshake, datapath-strobe and status bundle between mul_controller and
// its surroundings (operand source, mul_datapath, system status).
interface mul_controller_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             in_valid;
  logic             abort;
  logic             eqz;
  logic             in_ready;
  logic             ldA;
  logic             ldB;
  logic             clrP;
  logic             ldP;
  logic             decB;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] iter_count;

  modport master (
    input  start, in_valid, abort, eqz,
    output in_ready, ldA, ldB, clrP, ldP, decB, busy, done, aborted, iter_count
  );

  modport slave (
    output start, in_valid, abort, eqz,
    input  in_ready, ldA, ldB, clrP, ldP, decB, busy, done, aborted, iter_count
  );
endinterface

// File: rtl/mul_controller.sv
// Sequencing FSM for the repeated-addition multiplier: fetches A then B over a
// valid/ready handshake, steps the datapath until B reaches zero, reports status.
module mul_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] iter_count_r;
  logic             aborted_r;

  logic ld_a_s;
  logic ld_b_s;
  logic clr_p_s;
  logic ld_p_s;
  logic dec_b_s;
  logic iter_clr_s;
  logic iter_inc_s;
  logic abort_take_s;
  logic busy_s;
  logic done_s;
  logic in_ready_s;

  // The count sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // Next-state and strobe decode; abort wins over in_valid and eqz.
  always_comb begin
    state_nxt_s  = state_r;
    ld_a_s       = 1'b0;
    ld_b_s       = 1'b0;
    clr_p_s      = 1'b0;
    ld_p_s       = 1'b0;
    dec_b_s      = 1'b0;
    iter_clr_s   = 1'b0;
    iter_inc_s   = 1'b0;
    abort_take_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_LOAD_A;
          iter_clr_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        if (bus.abort) begin
          state_nxt_s  = ST_IDLE;
          abort_take_s = 1'b1;
        end else if (bus.in_valid) begin
          state_nxt_s = ST_LOAD_B;
          ld_a_s      = 1'b1;
        end else begin
          state_nxt_s = ST_LOAD_A;
        end
      end
      ST_LOAD_B: begin
        if (bus.abort) begin
          state_nxt_s  = ST_IDLE;
          abort_take_s = 1'b1;
        end else if (bus.in_valid) begin
          state_nxt_s = ST_ACCUM;
          ld_b_s      = 1'b1;
          clr_p_s     = 1'b1;
        end else begin
          state_nxt_s = ST_LOAD_B;
        end
      end
      ST_ACCUM: begin
        if (bus.abort) begin
          state_nxt_s  = ST_IDLE;
          abort_take_s = 1'b1;
        end else if (bus.eqz) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCUM;
          ld_p_s      = 1'b1;
          dec_b_s     = 1'b1;
          iter_inc_s  = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Status flags depend on the state register alone, so reset clears them at once.
  always_comb begin
    busy_s     = 1'b1;
    done_s     = 1'b0;
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:   busy_s     = 1'b0;
      ST_LOAD_A: in_ready_s = 1'b1;
      ST_LOAD_B: in_ready_s = 1'b1;
      ST_ACCUM:  busy_s     = 1'b1;
      ST_DONE:   done_s     = 1'b1;
      default:   busy_s     = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Iteration counter: cleared by an accepted start, otherwise held between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_count_r <= {CNT_W{1'b0}};
    end else if (iter_clr_s) begin
      iter_count_r <= {CNT_W{1'b0}};
    end else if (iter_inc_s) begin
      iter_count_r <= sat_inc(iter_count_r);
    end
  end

  // One-cycle pulse in the cycle after an abort is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_r <= 1'b0;
    end else begin
      aborted_r <= abort_take_s;
    end
  end

  assign bus.ldA        = ld_a_s;
  assign bus.ldB        = ld_b_s;
  assign bus.clrP       = clr_p_s;
  assign bus.ldP        = ld_p_s;
  assign bus.decB       = dec_b_s;
  assign bus.busy       = busy_s;
  assign bus.done       = done_s;
  assign bus.in_ready   = in_ready_s;
  assign bus.aborted    = aborted_r;
  assign bus.iter_count = iter_count_r;

endmodule
